// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a loaded pattern out MSB-first on x, with
// optional repetitions separated by GAP idle cycles.
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       reps,
    input  logic             start,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] pat;
    logic [LEN_W-1:0] plen, idx;
    logic [7:0]       preps, rem;
    logic [GW-1:0]    gcnt;

    function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
        return |(p & ({{(WIDTH-1){1'b0}}, 1'b1} << i));
    endfunction

    logic [LEN_W-1:0] len_c, e_len;
    logic [WIDTH-1:0] e_pat;
    logic [7:0]       e_reps;
    logic             first, last_rep;

    // A same-cycle load+start must transmit the freshly presented values.
    always_comb begin
        len_c    = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
        e_len    = load ? len_c : plen;
        e_pat    = load ? data : pat;
        e_reps   = load ? reps : preps;
        first    = bit_at(pat, plen - ONE);
        last_rep = rem <= 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pat   <= '0;
            plen  <= '0;
            preps <= '0;
            idx   <= '0;
            rem   <= '0;
            gcnt  <= '0;
            x     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        pat   <= data;
                        plen  <= len_c;
                        preps <= reps;
                    end
                    if (start && e_len != '0) begin
                        state <= S_SEND;
                        idx   <= e_len - ONE;
                        rem   <= (e_reps == 8'd0) ? 8'd1 : e_reps;
                        x     <= bit_at(e_pat, e_len - ONE);
                        valid <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (idx != '0) begin
                        idx <= idx - ONE;
                        x   <= bit_at(pat, idx - ONE);
                    end else if (!last_rep) begin
                        rem <= rem - 8'd1;
                        if (GAP > 0) begin
                            state <= S_GAP;
                            gcnt  <= GAP_INIT;
                            x     <= 1'b0;
                            valid <= 1'b0;
                        end else begin
                            idx <= plen - ONE;
                            x   <= first;
                        end
                    end else begin
                        rem   <= rem - 8'd1;
                        state <= S_DONE;
                        x     <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt == '0) begin
                        state <= S_SEND;
                        idx   <= plen - ONE;
                        x     <= first;
                        valid <= 1'b1;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench; expected bits (0/1) and done markers (2)
// are queued by the stimulus and consumed by a negedge monitor.
module tb_serial_pattern_tx;
    logic        clk = 0, rst_n = 0, load = 0, start = 0;
    logic [15:0] data = '0;
    logic [4:0]  len = '0;
    logic [7:0]  reps = '0;
    logic        x, valid, busy, done;
    int          checks = 0, errors = 0, busy_cnt = 0, seen;
    int          q[$];

    serial_pattern_tx dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .len(len),
        .reps(reps), .start(start), .x(x), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i] == 8'h31 ? 1 : 0);
        q.push_back(2);
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (!valid && x) chk("x_forced_zero", 1, 0);
        if (valid || done) begin
            if (q.size() == 0) chk("unexpected_output", valid ? int'(x) : 2, -1);
            else chk(valid ? "bit" : "done_pulse", valid ? int'(x) : 2, q.pop_front());
        end
    end

    task automatic wait_done(input int exp_busy);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic go(input logic [15:0] d, input logic [4:0] l, input logic [7:0] r,
                      input string bits, input int exp_busy);
        @(negedge clk);
        load = 1; data = d; len = l; reps = r; start = 1;
        busy_cnt = 0;
        push_str(bits);
        @(negedge clk);
        load = 0; start = 0;
        wait_done(exp_busy);
    endtask

    initial begin
        #1;
        chk("reset_outputs", {x, valid, busy, done}, 0);
        #13 rst_n = 1;

        go(16'h0006, 5'd4, 8'd1, "0110", 4);
        go(16'h000B, 5'd4, 8'd3, "101110111011", 14);
        go(16'h1234, 5'd3, 8'd0, "100", 3);

        // Zero-length start must be ignored.
        @(negedge clk);
        load = 1; len = 0; data = 16'hFFFF; reps = 1; start = 1;
        @(negedge clk);
        load = 0; start = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= int'(busy | valid | done);
        end
        chk("zero_len_idle", seen, 0);

        // load/start during SEND are ignored.
        @(negedge clk);
        load = 1; data = 16'h0004; len = 4; reps = 1; start = 1;
        busy_cnt = 0;
        push_str("0100");
        @(negedge clk);
        load = 1; data = 16'hFFFF; len = 8; start = 1;
        @(negedge clk);
        load = 0; start = 0;
        wait_done(4);
        @(negedge clk);
        start = 1;
        busy_cnt = 0;
        push_str("0100");
        @(negedge clk);
        start = 0;
        wait_done(4);

        go(16'hA5C3, 5'd16, 8'd1, "1010010111000011", 16);
        go(16'hA5C3, 5'd31, 8'd1, "1010010111000011", 16);

        // Asynchronous reset during bit 2 of a 16-bit send.
        @(negedge clk);
        load = 1; data = 16'hA5C3; len = 16; reps = 1; start = 1;
        q.push_back(1);
        q.push_back(0);
        @(negedge clk);
        load = 0; start = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_reset_outputs", {x, valid, busy, done}, 0);
        chk("async_reset_queue", q.size(), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= int'(busy | valid | done);
        end
        chk("start_after_reset_ignored", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
